// File: rtl/ipsxe_fft_bitrev_reorder_buf.sv
// Ping-pong reorder buffer: takes FFT frames in bit-reversed order, emits them in natural order.
// One write bank fills while the other drains through a registered output stage.
module ipsxe_fft_bitrev_reorder_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int LOG2_NFFT  = 4
) (
  input  logic                  clk,
  input  logic                  asyn_rst,
  input  logic                  i_valid,
  output logic                  i_ready,
  input  logic [DATA_WIDTH-1:0] i_data,
  input  logic                  i_last,
  output logic                  o_valid,
  input  logic                  o_ready,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                  o_last,
  output logic                  o_err
);

  localparam int N = 1 << LOG2_NFFT;
  localparam logic [LOG2_NFFT-1:0] CNT_LAST = {LOG2_NFFT{1'b1}};

  logic [DATA_WIDTH-1:0] mem0 [N];
  logic [DATA_WIDTH-1:0] mem1 [N];

  logic [1:0]           bank_full;
  logic                 wr_bank;
  logic                 rd_bank;
  logic [LOG2_NFFT-1:0] wr_cnt;
  logic [LOG2_NFFT-1:0] rd_cnt;
  logic [LOG2_NFFT-1:0] wr_addr;
  logic                 wr_fire;
  logic                 wr_end;
  logic                 rd_adv;
  logic                 rd_fire;
  logic                 rd_end;
  logic [DATA_WIDTH-1:0] rd_word;

  always_comb begin
    wr_addr = '0;
    for (int b = 0; b < LOG2_NFFT; b++) begin
      wr_addr[b] = wr_cnt[LOG2_NFFT-1-b];
    end
  end

  // A bank is writable only while EMPTY, so reads and writes never share a bank.
  assign i_ready = ~bank_full[wr_bank];
  assign wr_fire = i_valid & i_ready;
  assign wr_end  = wr_fire & (wr_cnt == CNT_LAST);

  assign rd_adv  = ~o_valid | o_ready;
  assign rd_fire = rd_adv & bank_full[rd_bank];
  assign rd_end  = rd_fire & (rd_cnt == CNT_LAST);
  assign rd_word = rd_bank ? mem1[rd_cnt] : mem0[rd_cnt];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      if (wr_bank) begin
        mem1[wr_addr] <= i_data;
      end else begin
        mem0[wr_addr] <= i_data;
      end
    end
  end

  always_ff @(posedge clk or posedge asyn_rst) begin
    if (asyn_rst) begin
      bank_full <= 2'b00;
      wr_bank   <= 1'b0;
      rd_bank   <= 1'b0;
      wr_cnt    <= '0;
      rd_cnt    <= '0;
      o_valid   <= 1'b0;
      o_data    <= '0;
      o_last    <= 1'b0;
      o_err     <= 1'b0;
    end else begin
      o_err <= wr_fire & (i_last != (wr_cnt == CNT_LAST));
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 1'b1;
      end
      if (wr_end) begin
        bank_full[wr_bank] <= 1'b1;
        wr_bank            <= ~wr_bank;
      end
      if (rd_adv) begin
        o_valid <= rd_fire;
      end
      // o_data/o_last hold when the bank is not ready, so only a real load touches them.
      if (rd_fire) begin
        o_data <= rd_word;
        o_last <= (rd_cnt == CNT_LAST);
        rd_cnt <= rd_cnt + 1'b1;
      end
      if (rd_end) begin
        bank_full[rd_bank] <= 1'b0;
        rd_bank            <= ~rd_bank;
      end
    end
  end

endmodule

// File: tb/tb_ipsxe_fft_bitrev_reorder_buf.sv
// Bench for the bit-reversal reorder buffer: directed N=8 scenarios plus a randomized N=16 run.
module tb_ipsxe_fft_bitrev_reorder_buf;

  logic clk = 1'b0;
  logic asyn_rst = 1'b0;
  always #5 clk = ~clk;

  logic        a_i_valid = 1'b0, a_i_ready, a_i_last = 1'b0;
  logic [31:0] a_i_data = '0, a_o_data;
  logic        a_o_valid, a_o_ready = 1'b1, a_o_last, a_o_err;
  logic        b_i_valid = 1'b0, b_i_ready, b_i_last = 1'b0;
  logic [31:0] b_i_data = '0, b_o_data;
  logic        b_o_valid, b_o_ready = 1'b1, b_o_last, b_o_err;

  ipsxe_fft_bitrev_reorder_buf #(.DATA_WIDTH(32), .LOG2_NFFT(3)) dut_a (
    .clk(clk), .asyn_rst(asyn_rst),
    .i_valid(a_i_valid), .i_ready(a_i_ready), .i_data(a_i_data), .i_last(a_i_last),
    .o_valid(a_o_valid), .o_ready(a_o_ready), .o_data(a_o_data), .o_last(a_o_last),
    .o_err(a_o_err)
  );

  ipsxe_fft_bitrev_reorder_buf #(.DATA_WIDTH(32), .LOG2_NFFT(4)) dut_b (
    .clk(clk), .asyn_rst(asyn_rst),
    .i_valid(b_i_valid), .i_ready(b_i_ready), .i_data(b_i_data), .i_last(b_i_last),
    .o_valid(b_o_valid), .o_ready(b_o_ready), .o_data(b_o_data), .o_last(b_o_last),
    .o_err(b_o_err)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int brev(input int k, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) if ((k >> i) & 1) r = r + (1 << (bits - 1 - i));
    return r;
  endfunction

  // Reference: buffer a whole input frame, then natural index n is input position brev(n).
  logic [31:0] a_frame[$], a_exp_d[$], b_frame[$], b_exp_d[$];
  int a_exp_i[$], b_exp_i[$];
  logic a_err_pend = 1'b0, b_err_pend = 1'b0;
  int a_out_cnt = 0, a_err_cnt = 0, a_stall_cnt = 0, b_out_cnt = 0;

  always @(negedge clk) if (!asyn_rst) begin
    chk("a_err", a_o_err, a_err_pend);
    if (a_o_err) a_err_cnt++;
    a_err_pend = 1'b0;
    if (a_i_valid && !a_i_ready) a_stall_cnt++;
    if (a_i_valid && a_i_ready) begin
      a_err_pend = (a_i_last != (a_frame.size() == 7));
      a_frame.push_back(a_i_data);
      if (a_frame.size() == 8) begin
        for (int n = 0; n < 8; n++) begin
          a_exp_d.push_back(a_frame[brev(n, 3)]);
          a_exp_i.push_back(n);
        end
        a_frame.delete();
      end
    end
    if (a_o_valid && a_o_ready) begin
      a_out_cnt++;
      if (a_exp_d.size() == 0) chk("a_extra_out", a_o_valid, 1'b0);
      else begin
        chk("a_data", a_o_data, a_exp_d.pop_front());
        chk("a_last", a_o_last, a_exp_i.pop_front() == 7);
      end
    end
  end

  always @(negedge clk) if (!asyn_rst) begin
    chk("b_err", b_o_err, b_err_pend);
    b_err_pend = 1'b0;
    if (b_i_valid && b_i_ready) begin
      b_err_pend = (b_i_last != (b_frame.size() == 15));
      b_frame.push_back(b_i_data);
      if (b_frame.size() == 16) begin
        for (int n = 0; n < 16; n++) begin
          b_exp_d.push_back(b_frame[brev(n, 4)]);
          b_exp_i.push_back(n);
        end
        b_frame.delete();
      end
    end
    if (b_o_valid && b_o_ready) begin
      b_out_cnt++;
      if (b_exp_d.size() == 0) chk("b_extra_out", b_o_valid, 1'b0);
      else begin
        chk("b_data", b_o_data, b_exp_d.pop_front());
        chk("b_last", b_o_last, b_exp_i.pop_front() == 15);
      end
    end
  end

  task automatic send_a(input logic [31:0] d, input logic last, output int waits);
    a_i_data = d; a_i_last = last; a_i_valid = 1'b1; waits = 0;
    while (1) begin
      @(negedge clk);
      if (a_i_ready) break;
      waits++;
      if (waits > 300) begin chk("a_send_timeout", waits, 0); break; end
    end
    @(posedge clk); #1;
    a_i_valid = 1'b0; a_i_last = 1'b0;
  endtask

  task automatic send_b(input logic [31:0] d, input logic last);
    int waits = 0;
    b_i_data = d; b_i_last = last; b_i_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (b_i_ready) break;
      waits++;
      if (waits > 300) begin chk("b_send_timeout", waits, 0); break; end
    end
    @(posedge clk); #1;
    b_i_valid = 1'b0; b_i_last = 1'b0;
  endtask

  task automatic drain_a();
    int t = 0;
    while ((a_exp_d.size() != 0 || a_o_valid) && t < 300) begin
      @(posedge clk); #1; t++;
    end
    chk("a_drain", a_exp_d.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, base;
    logic b_done;
    #1 asyn_rst = 1'b1;
    #2;
    chk("rst_o_valid", a_o_valid, 0);
    chk("rst_o_data", a_o_data, 0);
    chk("rst_o_last", a_o_last, 0);
    chk("rst_o_err", a_o_err, 0);
    repeat (2) @(posedge clk);
    #1 asyn_rst = 1'b0;
    chk("rst_i_ready", a_i_ready, 1);

    // single frame, first output one clock after sample N-1
    for (int k = 0; k < 8; k++) send_a(k, k == 7, w);
    chk("t1_ovalid_e0", a_o_valid, 0);
    @(posedge clk); #1;
    chk("t1_ovalid_e1", a_o_valid, 1);
    chk("t1_first", a_o_data, 0);
    drain_a();

    // back-to-back frames, no stall and no bubble
    a_stall_cnt = 0; base = a_out_cnt;
    for (int k = 0; k < 16; k++) send_a(k, (k % 8) == 7, w);
    repeat (8) @(posedge clk);
    #1;
    chk("t2_outs", a_out_cnt - base, 15);
    chk("t2_stalls", a_stall_cnt, 0);
    chk("t2_tail_vld", a_o_valid, 1);
    chk("t2_tail_dat", a_o_data, 15);
    chk("t2_tail_last", a_o_last, 1);
    drain_a();

    // downstream blocked while three frames arrive
    a_o_ready = 1'b0;
    for (int k = 0; k < 16; k++) send_a(k, (k % 8) == 7, w);
    a_i_data = 16; a_i_last = 1'b0; a_i_valid = 1'b1;
    @(posedge clk); #1;
    chk("t3_hold0", a_o_data, 0);
    repeat (4) @(posedge clk);
    #1;
    chk("t3_irdy", a_i_ready, 0);
    chk("t3_ovalid", a_o_valid, 1);
    chk("t3_hold1", a_o_data, 0);
    a_o_ready = 1'b1;
    send_a(16, 1'b0, w);
    chk("t3_rearm", w, 7);
    for (int k = 17; k < 24; k++) send_a(k, k == 23, w);
    drain_a();

    // misplaced i_last
    base = a_err_cnt;
    for (int k = 0; k < 8; k++) send_a(40 + k, k == 5, w);
    drain_a();
    chk("t4_errs", a_err_cnt - base, 2);

    // reset in the middle of the second bank while the first drains
    for (int k = 0; k < 13; k++) send_a(60 + k, k == 7, w);
    chk("t5_pre_vld", a_o_valid, 1);
    asyn_rst = 1'b1;
    a_frame.delete(); a_exp_d.delete(); a_exp_i.delete(); a_err_pend = 1'b0;
    #1;
    chk("t5_rst_vld", a_o_valid, 0);
    @(posedge clk); #1;
    asyn_rst = 1'b0;
    chk("t5_irdy", a_i_ready, 1);
    base = a_out_cnt;
    for (int k = 0; k < 8; k++) send_a(80 + k, k == 7, w);
    drain_a();
    chk("t5_outs", a_out_cnt - base, 8);

    // randomized stalls on both sides, N=16, 20 frames
    b_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 320; k++) begin
          if ($urandom_range(0, 1) == 1) begin
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1;
          end
          send_b($urandom, (k % 16) == 15);
        end
        b_done = 1'b1;
      end
      begin
        while (!b_done) begin
          @(posedge clk); #1;
          b_o_ready = ($urandom_range(0, 1) == 1);
        end
        b_o_ready = 1'b1;
      end
    join
    begin
      int t = 0;
      while ((b_exp_d.size() != 0 || b_o_valid) && t < 400) begin
        @(posedge clk); #1; t++;
      end
    end
    chk("b_outs", b_out_cnt, 320);
    chk("b_left", b_exp_d.size(), 0);
    chk("b_partial", b_frame.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/ipsxe_fft_bitrev_reorder_buf.md
Name: ipsxe_fft_bitrev_reorder_buf

Overview:
- Output-side reorder buffer for the radix-2 FFT core.
- Accepts frames of 2^LOG2_NFFT samples in bit-reversed order and emits them in natural order.
- Uses a ping-pong pair of distributed-RAM banks, so throughput is one sample per clock when downstream never stalls.
- Sits between the FFT butterfly pipeline output and the user AXI-stream-style result port.

Parameters:
- DATA_WIDTH, 32, sample width (re+im packed); range 1-256.
- LOG2_NFFT, 4, log2 of frame length N; range 3-10.

Ports:
- clk  in  1  clock; all logic rising-edge.
- asyn_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  input sample valid.
- i_ready  out  1  buffer can accept input.
- i_data  in  DATA_WIDTH  input sample, bit-reversed frame order.
- i_last  in  1  marks the last sample of an input frame.
- o_valid  out  1  output sample valid.
- o_ready  in  1  downstream accepts output.
- o_data  out  DATA_WIDTH  output sample, natural order.
- o_last  out  1  marks output sample index N-1.
- o_err  out  1  one-cycle pulse on i_last framing mismatch.

Behaviour:
- Reset (asynchronous, asyn_rst=1):
  - Both banks EMPTY; wr_bank=0, rd_bank=0, wr_cnt=0, rd_cnt=0.
  - o_valid=0, o_data=0, o_last=0, o_err=0.
  - i_ready=1 once reset is released.
  - Reset mid-frame discards all buffered data; no partial frame is ever output.
- Bank state, per bank:
  - EMPTY -> FULL on the edge accepting that bank's sample N-1.
  - FULL -> EMPTY on the edge that loads that bank's natural index N-1 into the output register.
- Write side:
  - Input handshake = i_valid & i_ready.
  - i_ready = (bank[wr_bank] == EMPTY); combinational from registered state.
  - Accepted sample k (k = wr_cnt) is written to address bitrev(k) over LOG2_NFFT bits in bank wr_bank.
  - wr_cnt increments per handshake. At k = N-1: wr_cnt wraps to 0, bank marked FULL, wr_bank toggles.
- i_last checking:
  - i_last is checked, not used for framing; the counter alone defines frame boundaries.
  - o_err pulses high for one cycle after a handshake where i_last != (wr_cnt == N-1).
- Read side:
  - Output register advances when (!o_valid | o_ready).
  - When it advances and bank[rd_bank] == FULL: o_data <= mem[rd_bank][rd_cnt], o_valid <= 1, o_last <= (rd_cnt == N-1), rd_cnt increments.
  - At rd_cnt == N-1: rd_cnt wraps to 0, bank marked EMPTY, rd_bank toggles.
  - When it advances and bank[rd_bank] != FULL: o_valid <= 0. o_data and o_last hold their values.
  - When o_valid=1 and o_ready=0: o_data, o_valid and o_last hold stable. No bank or counter changes on the read side.
- RAM: distributed, asynchronous read, synchronous write. A read and a write never target the same bank in the same cycle.
- Latency:
  - Input edge E0 accepts sample N-1 of a frame.
  - At edge E1 o_valid=1 with natural index 0, provided the output register can advance.
- Freed-bank timing: a bank freed at edge E makes i_ready=1 in the cycle after E. No same-cycle bypass.
- Throughput: with o_ready held at 1, continuous input sustains 1 sample/clk and i_ready never drops.
- Both banks FULL: i_ready=0 until the read side frees rd_bank.

Test Plan:
- N=8, one frame, input i_data=k for k=0..7, i_last on k=7, o_ready=1:
  - o_data sequence 0,4,2,6,1,5,3,7.
  - o_last only on the 8th output.
  - First o_valid exactly 1 clock after the k=7 handshake.
- N=8, back-to-back frames, data 0..15, i_valid=1, o_ready=1:
  - i_ready stays 1 throughout.
  - Outputs 0,4,2,6,1,5,3,7,8,12,10,14,9,13,11,15 with no bubble between frames.
- N=8, o_ready=0 held through three input frames:
  - i_ready=0 after 16 accepted samples.
  - o_data holds value 0 stable.
  - Releasing o_ready drains both frames in correct order.
  - i_ready reasserts one cycle after the first bank drains.
- N=8, i_last asserted on k=5 and deasserted on k=7:
  - o_err pulses once after each of those two handshakes.
  - Output order is unaffected.
- Random i_valid/o_ready stalls (~50%), N=16, 20 frames:
  - Scoreboard equals a natural-order reference model.
  - No dropped or duplicated samples.
- asyn_rst pulsed mid-frame (after 5 samples of bank 1 while bank 0 drains):
  - o_valid=0 immediately; i_ready=1 after release.
  - The next full frame outputs correctly with no stale data.
